// File: rtl/stacker_pkg.sv
// Shared types and constants for the stacker game display path.
package stacker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [3:0] MAX_DIGIT   = 4'd9;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear; saturates at 99.
module bcd2_counter
  import stacker_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic at_max;

  assign at_max = (tens == MAX_DIGIT) && (ones == MAX_DIGIT);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc && !at_max) begin
      if (ones == MAX_DIGIT) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_controller.sv
// Score/high-score sequencing for the stacker game's two-digit display:
// high score in IDLE, live score in PLAY, blinking final score in OVER.
module score_controller
  import stacker_pkg::*;
#(
  parameter int unsigned BLINK_TICKS = 4,
  parameter int unsigned OVER_TICKS  = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       new_game,
  input  logic       score_inc,
  input  logic       game_over,
  output logic [3:0] value0,
  output logic [3:0] value1,
  output logic       playing
);

  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  localparam int unsigned OW = $clog2(OVER_TICKS + 1);

  state_t        state_q, state_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [OW-1:0] over_q, over_d;
  logic          blank_q, blank_d;
  logic [3:0]    high_tens_q, high_tens_d;
  logic [3:0]    high_ones_q, high_ones_d;
  logic [3:0]    score_tens, score_ones;
  logic          score_clear, score_step;

  bcd2_counter u_score (
    .clock (clock),
    .reset (reset),
    .clear (score_clear),
    .inc   (score_step),
    .tens  (score_tens),
    .ones  (score_ones)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      blink_q     <= '0;
      over_q      <= '0;
      blank_q     <= 1'b0;
      high_tens_q <= 4'd0;
      high_ones_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      blink_q     <= blink_d;
      over_q      <= over_d;
      blank_q     <= blank_d;
      high_tens_q <= high_tens_d;
      high_ones_q <= high_ones_d;
    end
  end

  // Next state; new_game beats game_over beats score_inc.
  always_comb begin
    state_d     = state_q;
    blink_d     = blink_q;
    over_d      = over_q;
    blank_d     = blank_q;
    high_tens_d = high_tens_q;
    high_ones_d = high_ones_q;
    score_clear = 1'b0;
    score_step  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (new_game) begin
          state_d     = PLAY;
          score_clear = 1'b1;
        end
      end
      PLAY: begin
        if (new_game) begin
          score_clear = 1'b1;
        end else if (game_over) begin
          state_d = OVER;
          blink_d = '0;
          over_d  = '0;
          blank_d = 1'b0;
          // Packed BCD compares tens first, then ones.
          if ({score_tens, score_ones} > {high_tens_q, high_ones_q}) begin
            high_tens_d = score_tens;
            high_ones_d = score_ones;
          end
        end else if (score_inc) begin
          score_step = 1'b1;
        end
      end
      OVER: begin
        if (new_game) begin
          state_d     = PLAY;
          score_clear = 1'b1;
          blink_d     = '0;
          over_d      = '0;
          blank_d     = 1'b0;
        end else if (tick) begin
          if (over_q == OW'(OVER_TICKS - 1)) begin
            state_d = IDLE;
            blink_d = '0;
            over_d  = '0;
            blank_d = 1'b0;
          end else begin
            over_d = over_q + OW'(1);
            if (blink_q == BW'(BLINK_TICKS - 1)) begin
              blink_d = '0;
              blank_d = ~blank_q;
            end else begin
              blink_d = blink_q + BW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display mux driven only by registered state.
  always_comb begin
    value1  = score_tens;
    value0  = score_ones;
    playing = 1'b0;
    unique case (state_q)
      IDLE: begin
        value1 = high_tens_q;
        value0 = high_ones_q;
      end
      PLAY: playing = 1'b1;
      OVER: begin
        if (blank_q) begin
          value1 = BLANK_DIGIT;
          value0 = BLANK_DIGIT;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_score_controller.sv
// Scoreboard bench for score_controller: the driver queues hand-computed
// display values, a negedge monitor pops and compares them.
module tb_score_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       new_game = 1'b0;
  logic       score_inc = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] value0, value1;
  logic       playing;

  score_controller #(.BLINK_TICKS(4), .OVER_TICKS(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .new_game  (new_game),
    .score_inc (score_inc),
    .game_over (game_over),
    .value0    (value0),
    .value1    (value1),
    .playing   (playing)
  );

  always #5 clock = ~clock;

  // Input bundle: {reset, new_game, score_inc, game_over, tick}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] R    = 5'b10000;
  localparam logic [4:0] NG   = 5'b01000;
  localparam logic [4:0] SI   = 5'b00100;
  localparam logic [4:0] GO   = 5'b00010;
  localparam logic [4:0] TK   = 5'b00001;

  typedef struct {
    int         due;
    logic [3:0] v1;
    logic [3:0] v0;
    logic       pl;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if ({value1, value0, playing} !== {e.v1, e.v0, e.pl}) begin
        n_err++;
        $display("FAIL %s: got %h/%h playing=%b, expected %h/%h playing=%b",
                 e.nm, value1, value0, playing, e.v1, e.v0, e.pl);
      end
    end
  end

  task automatic step(input logic [4:0] in, input bit chk, input logic [3:0] e1,
                      input logic [3:0] e0, input logic ep, input string nm);
    exp_t e;
    @(negedge clock);
    {reset, new_game, score_inc, game_over, tick} = in;
    if (chk) begin
      e.due = cyc + 1;
      e.v1  = e1;
      e.v0  = e0;
      e.pl  = ep;
      e.nm  = nm;
      sb.push_back(e);
    end
  endtask

  task automatic go(input logic [4:0] in);
    step(in, 1'b0, 4'h0, 4'h0, 1'b0, "");
  endtask

  task automatic chk(input logic [4:0] in, input logic [3:0] e1, input logic [3:0] e0,
                     input logic ep, input string nm);
    step(in, 1'b1, e1, e0, ep, nm);
  endtask

  task automatic repeat_in(input logic [4:0] in, input int n);
    for (int i = 0; i < n; i++) go(in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and first game
    go(R);
    chk(R, 4'h0, 4'h0, 1'b0, "reset_2cyc");
    chk(NONE, 4'h0, 4'h0, 1'b0, "idle_after_reset");
    chk(NG, 4'h0, 4'h0, 1'b1, "new_game");

    // Counting, carry, tick ignored in PLAY
    repeat_in(SI, 11);
    chk(SI, 4'h1, 4'h2, 1'b1, "inc12");
    chk(TK, 4'h1, 4'h2, 1'b1, "tick_play");
    chk(NG, 4'h0, 4'h0, 1'b1, "restart");
    repeat_in(SI, 8);
    chk(SI, 4'h0, 4'h9, 1'b1, "inc9");
    chk(SI, 4'h1, 4'h0, 1'b1, "carry");

    // Saturation, then score_inc dropped under game_over
    chk(NG, 4'h0, 4'h0, 1'b1, "restart_sat");
    repeat_in(SI, 104);
    chk(SI, 4'h9, 4'h9, 1'b1, "saturate");
    chk(SI | GO, 4'h9, 4'h9, 1'b0, "inc_go_same");

    // Clear high via reset, set high to 20
    chk(R, 4'h0, 4'h0, 1'b0, "reset_high");
    chk(NG, 4'h0, 4'h0, 1'b1, "game20_start");
    repeat_in(SI, 20);
    chk(GO, 4'h2, 4'h0, 1'b0, "game20_over");
    chk(NG, 4'h0, 4'h0, 1'b1, "ng_in_over");
    repeat_in(SI, 37);
    chk(GO, 4'h3, 4'h7, 1'b0, "game37_over");

    // Blink over 32 ticks, one no-tick cycle inserted
    for (int t = 1; t <= 32; t++) begin
      if (t == 32)
        chk(TK, 4'h3, 4'h7, 1'b0, "over_to_idle_high37");
      else if (((t / 4) % 2) == 1)
        chk(TK, 4'hF, 4'hF, 1'b0, $sformatf("blink_t%0d", t));
      else
        chk(TK, 4'h3, 4'h7, 1'b0, $sformatf("blink_t%0d", t));
      if (t == 5) chk(NONE, 4'hF, 4'hF, 1'b0, "no_tick_hold");
    end
    chk(TK, 4'h3, 4'h7, 1'b0, "tick_idle");
    chk(GO, 4'h3, 4'h7, 1'b0, "go_idle");
    chk(SI, 4'h3, 4'h7, 1'b0, "inc_idle");

    // Lower second game keeps high 37
    chk(NG, 4'h0, 4'h0, 1'b1, "game15_start");
    repeat_in(SI, 15);
    chk(GO, 4'h1, 4'h5, 1'b0, "game15_over");
    chk(GO, 4'h1, 4'h5, 1'b0, "go_in_over");
    chk(SI, 4'h1, 4'h5, 1'b0, "inc_in_over");
    repeat_in(TK, 31);
    chk(TK, 4'h3, 4'h7, 1'b0, "high_kept");

    // new_game aborts blank phase; new_game beats game_over
    chk(NG, 4'h0, 4'h0, 1'b1, "game3_start");
    repeat_in(SI, 3);
    chk(GO, 4'h0, 4'h3, 1'b0, "game3_over");
    repeat_in(TK, 3);
    chk(TK, 4'hF, 4'hF, 1'b0, "blank_phase");
    chk(NG, 4'h0, 4'h0, 1'b1, "ng_blank");
    repeat_in(SI, 2);
    chk(NG | GO, 4'h0, 4'h0, 1'b1, "ng_go_same");

    // Reset mid-OVER and mid-PLAY
    repeat_in(SI, 4);
    chk(SI, 4'h0, 4'h5, 1'b1, "game5_score");
    chk(GO, 4'h0, 4'h5, 1'b0, "game5_over");
    repeat_in(TK, 4);
    chk(R, 4'h0, 4'h0, 1'b0, "reset_over");
    chk(NONE, 4'h0, 4'h0, 1'b0, "idle_high_cleared");
    chk(NG, 4'h0, 4'h0, 1'b1, "play_again");
    chk(SI, 4'h0, 4'h1, 1'b1, "play_inc");
    chk(R, 4'h0, 4'h0, 1'b0, "reset_play");

    go(NONE);
    go(NONE);
    go(NONE);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      n_err += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
